batcharger_ctrl_mc: RTL and testbench

BATCHARGER_CTRL_MC -- requirements
Module: batcharger_ctrl_mc

---
 rtl/batcharger_pkg.sv | 28 ++
 rtl/batcharger_ch_fsm.sv | 98 +++++++++
 rtl/batcharger_ctrl_mc.sv | 61 ++++++
 tb/tb_batcharger_ctrl_mc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/batcharger_pkg.sv
// Shared state encoding, mode width and setpoint helpers for the multi-channel charger.
package batcharger_pkg;

    localparam int unsigned MODE_W    = 3;
    localparam int unsigned TC_SHIFT  = 3;
    localparam int unsigned END_SHIFT = 4;

    typedef enum logic [MODE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_TC    = 3'd1,
        ST_CC    = 3'd2,
        ST_CV    = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    // CC current code for a capacity select, saturated to the DAC range.
    function automatic int unsigned icc_code(input logic [3:0] sel,
                                             input int unsigned step,
                                             input int unsigned w);
        int unsigned prod;
        int unsigned lim;
        prod = (32'(sel) + 32'd1) * step;
        lim  = (32'd1 << w) - 32'd1;
        return (prod > lim) ? lim : prod;
    endfunction

endpackage

// File: rtl/batcharger_ch_fsm.sv
// One charger channel: trickle/CC/CV/done/fault FSM with CV timer and registered outputs.
module batcharger_ch_fsm
    import batcharger_pkg::*;
#(
    parameter int unsigned W        = 10,
    parameter int unsigned TW       = 16,
    parameter int unsigned ICC_STEP = 16
) (
    input  logic              clk,
    input  logic              rstz,
    input  logic              en,
    input  logic              chen,
    input  logic              adc_valid,
    input  logic [W-1:0]      vbat,
    input  logic [W-1:0]      ibat,
    input  logic [W-1:0]      vtemp,
    input  logic [3:0]        sel,
    input  logic [W-1:0]      vcutoff,
    input  logic [W-1:0]      vtarget,
    input  logic [W-1:0]      vrech,
    input  logic [W-1:0]      tmin,
    input  logic [W-1:0]      tmax_code,
    input  logic [TW-1:0]     tmax,
    output logic [W-1:0]      iset,
    output logic              cv_en,
    output logic [MODE_W-1:0] mode,
    output logic              done,
    output logic              fault
);

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d, timer_inc;
    logic [W-1:0]        iset_q;
    logic [MODE_W-1:0]   mode_q;
    logic                cv_en_q, done_q, fault_q;
    logic [W-1:0]        icc, itc, iend;
    logic                temp_bad;

    assign icc       = W'(icc_code(sel, ICC_STEP, W));
    assign itc       = icc >> TC_SHIFT;
    assign iend      = icc >> END_SHIFT;
    assign temp_bad  = (vtemp < tmin) || (vtemp > tmax_code);
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);

    always_comb begin
        state_d = state_q;
        if (!en || !chen) begin
            state_d = ST_IDLE;
        end else if (adc_valid) begin
            if (state_q != ST_IDLE && temp_bad) begin
                state_d = ST_FAULT;
            end else begin
                case (state_q)
                    ST_IDLE:  state_d = temp_bad ? ST_FAULT : ((vbat < vcutoff) ? ST_TC : ST_CC);
                    ST_TC:    if (vbat >= vcutoff) state_d = ST_CC;
                    ST_CC:    if (vbat >= vtarget) state_d = ST_CV;
                    // timeout compares the count including this cycle
                    ST_CV:    if ((ibat <= iend) || (timer_inc >= tmax)) state_d = ST_DONE;
                    ST_DONE:  if (vbat < vrech) state_d = ST_CC;
                    ST_FAULT: state_d = ST_IDLE;
                    default:  state_d = ST_IDLE;
                endcase
            end
        end
        timer_d = ((state_q == ST_CV) && (state_d == ST_CV)) ? timer_inc : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            iset_q  <= '0;
            mode_q  <= '0;
            cv_en_q <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mode_q  <= state_q;
            cv_en_q <= (state_q == ST_CV);
            done_q  <= (state_q == ST_DONE);
            fault_q <= (state_q == ST_FAULT);
            case (state_q)
                ST_TC:        iset_q <= itc;
                ST_CC, ST_CV: iset_q <= icc;
                default:      iset_q <= '0;
            endcase
        end
    end

    assign iset  = iset_q;
    assign mode  = mode_q;
    assign cv_en = cv_en_q;
    assign done  = done_q;
    assign fault = fault_q;

endmodule

// File: rtl/batcharger_ctrl_mc.sv
// Multi-channel battery charger controller: NCH independent channel FSMs on sliced buses.
module batcharger_ctrl_mc
    import batcharger_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned W        = 10,
    parameter int unsigned TW       = 16,
    parameter int unsigned ICC_STEP = 16
) (
    input  logic [0:0]          clk,
    input  logic [0:0]          rstz,
    input  logic [0:0]          en,
    input  logic [NCH-1:0]      chen,
    input  logic [NCH-1:0]      adc_valid,
    input  logic [NCH*W-1:0]    vbat,
    input  logic [NCH*W-1:0]    ibat,
    input  logic [NCH*W-1:0]    vtemp,
    input  logic [NCH*4-1:0]    sel,
    input  logic [W-1:0]        vcutoff,
    input  logic [W-1:0]        vtarget,
    input  logic [W-1:0]        vrech,
    input  logic [W-1:0]        tmin,
    input  logic [W-1:0]        tmax_code,
    input  logic [TW-1:0]       tmax,
    output logic [NCH*W-1:0]    iset,
    output logic [NCH-1:0]      cv_en,
    output logic [NCH*MODE_W-1:0] mode,
    output logic [NCH-1:0]      done,
    output logic [NCH-1:0]      fault
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        batcharger_ch_fsm #(
            .W        (W),
            .TW       (TW),
            .ICC_STEP (ICC_STEP)
        ) u_ch (
            .clk       (clk[0]),
            .rstz      (rstz[0]),
            .en        (en[0]),
            .chen      (chen[k]),
            .adc_valid (adc_valid[k]),
            .vbat      (vbat[k*W +: W]),
            .ibat      (ibat[k*W +: W]),
            .vtemp     (vtemp[k*W +: W]),
            .sel       (sel[k*4 +: 4]),
            .vcutoff   (vcutoff),
            .vtarget   (vtarget),
            .vrech     (vrech),
            .tmin      (tmin),
            .tmax_code (tmax_code),
            .tmax      (tmax),
            .iset      (iset[k*W +: W]),
            .cv_en     (cv_en[k]),
            .mode      (mode[k*MODE_W +: MODE_W]),
            .done      (done[k]),
            .fault     (fault[k])
        );
    end

endmodule

// File: tb/tb_batcharger_ctrl_mc.sv
// Bench for batcharger_ctrl_mc: directed charge scenarios plus randomized traffic against a reference model.
module tb_batcharger_ctrl_mc;

    localparam int NCH      = 2;
    localparam int W        = 10;
    localparam int TW       = 16;
    localparam int ICC_STEP = 16;

    logic                 clk = 1'b0;
    logic                 rstz, en;
    logic [NCH-1:0]       chen, adc_valid;
    logic [NCH*W-1:0]     vbat, ibat, vtemp;
    logic [NCH*4-1:0]     sel;
    logic [W-1:0]         vcutoff, vtarget, vrech, tmin, tmax_code;
    logic [TW-1:0]        tmax;
    logic [NCH*W-1:0]     iset;
    logic [NCH-1:0]       cv_en, done, fault;
    logic [NCH*3-1:0]     mode;

    batcharger_ctrl_mc #(
        .NCH      (NCH),
        .W        (W),
        .TW       (TW),
        .ICC_STEP (ICC_STEP)
    ) dut (
        .clk       (clk),
        .rstz      (rstz),
        .en        (en),
        .chen      (chen),
        .adc_valid (adc_valid),
        .vbat      (vbat),
        .ibat      (ibat),
        .vtemp     (vtemp),
        .sel       (sel),
        .vcutoff   (vcutoff),
        .vtarget   (vtarget),
        .vrech     (vrech),
        .tmin      (tmin),
        .tmax_code (tmax_code),
        .tmax      (tmax),
        .iset      (iset),
        .cv_en     (cv_en),
        .mode      (mode),
        .done      (done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 0;

    // Reference model: charge phase per channel and cycles spent in CV so far.
    int m_phase [NCH];
    int m_cvage [NCH];
    int e_iset  [NCH];
    int e_mode  [NCH];
    int e_cv    [NCH];
    int e_done  [NCH];
    int e_fault [NCH];

    function automatic int cc_current(input int s);
        int p;
        p = (s + 1) * ICC_STEP;
        return (p > (1 << W) - 1) ? (1 << W) - 1 : p;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            int vb, ib, vt, icc, ph, nph, age;
            bit hot;
            vb  = int'(vbat[k*W +: W]);
            ib  = int'(ibat[k*W +: W]);
            vt  = int'(vtemp[k*W +: W]);
            icc = cc_current(int'(sel[k*4 +: 4]));
            ph  = m_phase[k];
            if (!rstz) begin
                m_phase[k] = 0; m_cvage[k] = 0;
                e_iset[k] = 0; e_mode[k] = 0; e_cv[k] = 0; e_done[k] = 0; e_fault[k] = 0;
            end else begin
                e_mode[k]  = ph;
                e_iset[k]  = (ph == 1) ? icc / 8 : ((ph == 2 || ph == 3) ? icc : 0);
                e_cv[k]    = (ph == 3) ? 1 : 0;
                e_done[k]  = (ph == 4) ? 1 : 0;
                e_fault[k] = (ph == 5) ? 1 : 0;
                age = (ph == 3) ? ((m_cvage[k] < 65535) ? m_cvage[k] + 1 : 65535) : 0;
                hot = (vt < int'(tmin)) || (vt > int'(tmax_code));
                nph = ph;
                if (!en || !chen[k]) nph = 0;
                else if (adc_valid[k]) begin
                    if (ph != 0 && hot) nph = 5;
                    else if (ph == 0) nph = hot ? 5 : ((vb < int'(vcutoff)) ? 1 : 2);
                    else if (ph == 1 && vb >= int'(vcutoff)) nph = 2;
                    else if (ph == 2 && vb >= int'(vtarget)) nph = 3;
                    else if (ph == 3 && (ib <= icc / 16 || age >= int'(tmax))) nph = 4;
                    else if (ph == 4 && vb < int'(vrech)) nph = 2;
                    else if (ph == 5) nph = 0;
                end
                m_cvage[k] = (ph == 3 && nph == 3) ? age : 0;
                m_phase[k] = nph;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < NCH; k++) begin
                vectors++;
                if (int'(iset[k*W +: W]) != e_iset[k] || int'(mode[k*3 +: 3]) != e_mode[k] ||
                    int'(cv_en[k]) != e_cv[k] || int'(done[k]) != e_done[k] || int'(fault[k]) != e_fault[k]) begin
                    miscompares++;
                    $display("FAIL model ch%0d t=%0t: got iset=%0d mode=%0d cv=%0d done=%0d fault=%0d, expected iset=%0d mode=%0d cv=%0d done=%0d fault=%0d",
                             k, $time, iset[k*W +: W], mode[k*3 +: 3], cv_en[k], done[k], fault[k],
                             e_iset[k], e_mode[k], e_cv[k], e_done[k], e_fault[k]);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NCH-1:0] v);
        adc_valid = v;
        cyc(1);
        adc_valid = '0;
        cyc(1);
    endtask

    task automatic setch(input int k, input int vb, input int ib, input int vt, input int s);
        vbat[k*W +: W]  = W'(vb);
        ibat[k*W +: W]  = W'(ib);
        vtemp[k*W +: W] = W'(vt);
        sel[k*4 +: 4]   = 4'(s);
    endtask

    function automatic int o_iset(input int k); return int'(iset[k*W +: W]); endfunction
    function automatic int o_mode(input int k); return int'(mode[k*3 +: 3]); endfunction

    initial begin
        for (int k = 0; k < NCH; k++) begin m_phase[k] = 0; m_cvage[k] = 0; end
        rstz = 1'b0; en = 1'b0; chen = '0; adc_valid = '0;
        vbat = '0; ibat = '0; vtemp = '0; sel = '0;
        vcutoff = 10'd300; vtarget = 10'd420; vrech = 10'd400;
        tmin = 10'd100; tmax_code = 10'd900; tmax = 16'd1000;
        cyc(1);
        checking = 1;
        cyc(1);
        chk("reset_mode0", o_mode(0), 0);
        chk("reset_iset0", o_iset(0), 0);

        rstz = 1'b1; en = 1'b1; chen = 2'b11;
        setch(0, 250, 100, 500, 8);
        setch(1, 200, 100, 500, 3);
        cyc(1);
        pulse(2'b11);
        chk("tc_iset0", o_iset(0), 18);
        chk("tc_mode0", o_mode(0), 1);
        chk("tc_iset1", o_iset(1), 8);

        setch(0, 300, 100, 500, 8);
        pulse(2'b01);
        chk("cc_iset0", o_iset(0), 144);
        chk("cc_mode0", o_mode(0), 2);
        chk("tc_hold_mode1", o_mode(1), 1);

        chen = 2'b01;
        cyc(2);
        chk("chen_off_mode1", o_mode(1), 0);
        chk("chen_off_iset1", o_iset(1), 0);
        chk("chen_other_mode0", o_mode(0), 2);
        chk("chen_other_iset0", o_iset(0), 144);
        chen = 2'b11;

        setch(0, 420, 100, 500, 8);
        cyc(3);
        chk("novalid_hold_mode0", o_mode(0), 2);
        pulse(2'b01);
        chk("cv_cven0", int'(cv_en[0]), 1);
        chk("cv_mode0", o_mode(0), 3);

        setch(0, 420, 100, 500, 9);
        cyc(1);
        chk("sel_change_iset0", o_iset(0), 160);
        chk("sel_change_mode0", o_mode(0), 3);
        setch(0, 420, 9, 500, 8);
        pulse(2'b01);
        chk("done_flag0", int'(done[0]), 1);
        chk("done_iset0", o_iset(0), 0);
        chk("done_mode0", o_mode(0), 4);

        setch(0, 399, 9, 500, 8);
        pulse(2'b01);
        chk("recharge_mode0", o_mode(0), 2);
        chk("recharge_iset0", o_iset(0), 144);
        setch(0, 420, 9, 500, 8);
        pulse(2'b01);
        chk("recv_mode0", o_mode(0), 3);
        rstz = 1'b0;
        cyc(1);
        rstz = 1'b1;
        chk("midcv_reset_mode0", o_mode(0), 0);
        chk("midcv_reset_cv0", int'(cv_en[0]), 0);
        chk("midcv_reset_iset0", o_iset(0), 0);

        setch(0, 420, 100, 500, 8);
        adc_valid = 2'b01;
        cyc(2);
        cyc(1000);
        chk("timeout_before_done0", int'(done[0]), 0);
        chk("timeout_before_mode0", o_mode(0), 3);
        cyc(1);
        chk("timeout_done0", int'(done[0]), 1);
        adc_valid = '0;

        setch(0, 350, 100, 500, 8);
        pulse(2'b01);
        chk("temp_cc_mode0", o_mode(0), 2);
        setch(0, 350, 100, 950, 8);
        pulse(2'b01);
        chk("hot_fault0", int'(fault[0]), 1);
        chk("hot_iset0", o_iset(0), 0);
        setch(0, 350, 100, 900, 8);
        pulse(2'b01);
        chk("cool_mode0", o_mode(0), 0);
        pulse(2'b01);
        chk("restart_mode0", o_mode(0), 2);
        setch(0, 350, 100, 99, 8);
        pulse(2'b01);
        chk("cold_fault0", int'(fault[0]), 1);
        setch(0, 350, 100, 100, 8);
        pulse(2'b01);
        chk("tmin_edge_mode0", o_mode(0), 0);

        for (int n = 0; n < 2500; n++) begin
            if (n % 400 == 0) tmax = 16'($urandom_range(0, 60));
            rstz = ($urandom_range(0, 199) != 0);
            en   = ($urandom_range(0, 79) != 0);
            for (int k = 0; k < NCH; k++) begin
                int vt, s;
                chen[k]      = ($urandom_range(0, 39) != 0);
                adc_valid[k] = $urandom_range(0, 1) == 1;
                vt = ($urandom_range(0, 9) < 8) ? $urandom_range(100, 900) : $urandom_range(50, 950);
                s  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : int'(sel[k*4 +: 4]);
                setch(k, $urandom_range(200, 480), $urandom_range(0, 300), vt, s);
            end
            cyc(1);
        end

        cyc(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
